// File: rtl/fifo_port_arbiter.sv
// rtl/fifo_port_arbiter.sv - round-robin write arbiter and valid/ready read sequencer for a shift FIFO
module fifo_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          drop,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      fifo_rd_en,
    input  logic [DATA_W-1:0]         fifo_rd_data,
    input  logic                      fifo_overflow,
    input  logic                      fifo_underflow,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty,
    output logic                      err
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rstate_t;

    rstate_t             state_q;
    logic [N_REQ-1:0]    gnt_q, drop_q;
    logic                wr_en_q, rd_en_q;
    logic [DATA_W-1:0]   wr_data_q, out_data_q;
    logic                out_valid_q, full_q, empty_q, err_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    ptr_q, win_idx;
    logic [N_REQ-1:0]    req_eff;
    logic                win_found, grant;
    logic [DATA_W-1:0]   win_data;

    // count_d already folds in the write/read currently on the FIFO pins,
    // so a grant decided now can never land on a full buffer.
    always_comb begin
        count_d = count_q;
        case ({wr_en_q, rd_en_q})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        req_eff   = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!win_found && req_eff[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
        win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
        grant    = win_found && (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q     <= '0;
            drop_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            ptr_q     <= PTR_W'(N_REQ - 1);
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            gnt_q   <= '0;
            drop_q  <= '0;
            wr_en_q <= 1'b0;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
            err_q   <= err_q | fifo_overflow | fifo_underflow;
            if (grant) begin
                gnt_q <= N_REQ'(1) << win_idx;
                ptr_q <= win_idx;
                // Zero is the FIFO's empty marker: grant the port but discard the word.
                if (win_data != '0) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= win_data;
                end else begin
                    drop_q <= N_REQ'(1) << win_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= R_IDLE;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (count_q != '0) begin
                        rd_en_q <= 1'b1;
                        state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    out_data_q  <= fifo_rd_data;
                    out_valid_q <= 1'b1;
                    state_q     <= R_HOLD;
                end
                R_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (count_q != '0) begin
                            rd_en_q <= 1'b1;
                            state_q <= R_WAIT;
                        end else begin
                            state_q <= R_IDLE;
                        end
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign drop         = drop_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_rd_en   = rd_en_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign err          = err_q;
endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb/tb_fifo_port_arbiter.sv - directed bench for fifo_port_arbiter with a behavioural shift FIFO
module tb_fifo_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt, drop;
    logic        fifo_wr_en, fifo_rd_en;
    logic [7:0]  fifo_wr_data, fifo_rd_data;
    logic        fifo_overflow, fifo_underflow;
    logic        out_valid, out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [4:0]  count;
    logic        full, empty, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_port_arbiter #(.N_REQ(4), .DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .drop(drop),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .err(err)
    );

    // Behavioural FIFO: head word visible on data_out, popped on en_read.
    logic [7:0] mem [0:31];
    int  m_wp, m_rp, m_cnt;
    logic m_ovf, m_unf, force_unf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_wp <= 0; m_rp <= 0; m_cnt <= 0; m_ovf <= 1'b0; m_unf <= 1'b0;
        end else begin
            if (fifo_wr_en) begin
                mem[m_wp] <= fifo_wr_data;
                m_wp <= (m_wp + 1) % 32;
            end
            if (fifo_rd_en) m_rp <= (m_rp + 1) % 32;
            m_cnt <= m_cnt + (fifo_wr_en ? 1 : 0) - (fifo_rd_en ? 1 : 0);
            m_ovf <= fifo_wr_en && !fifo_rd_en && (m_cnt >= 16);
            m_unf <= fifo_rd_en && (m_cnt == 0);
        end
    end

    always_comb begin
        fifo_rd_data = 8'h00;
        if (m_cnt > 0) fifo_rd_data = mem[m_rp];
    end
    assign fifo_overflow  = m_ovf;
    assign fifo_underflow = m_unf | force_unf;

    logic [7:0] rx_q [$];
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) rx_q.push_back(out_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req = '0;
        out_ready = 1'b0;
        force_unf = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rx_q.delete();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] drop;
        logic       wr;
        logic [7:0] wdata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n, idx, cyc;
        int gseq [5];
        logic [7:0] dseq [5];
        logic [7:0] exp_rx [7];
        logic [7:0] d;
        logic got, seen, bad;
        int maxc, nwr;

        // port3..port0 data = D3, 00, B1, A0; state carries from row to row
        tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 8'hA0};
        tbl[1] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[2] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 8'hA0};
        tbl[3] = '{4'b1010, 4'b0010, 4'b0000, 1'b1, 8'hB1};
        tbl[4] = '{4'b1010, 4'b1000, 4'b0000, 1'b1, 8'hD3};
        tbl[5] = '{4'b0110, 4'b0010, 4'b0000, 1'b1, 8'hB1};
        tbl[6] = '{4'b0110, 4'b0100, 4'b0100, 1'b0, 8'h00};
        tbl[7] = '{4'b1001, 4'b1000, 4'b0000, 1'b1, 8'hD3};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[9] = '{4'b1111, 4'b0001, 4'b0000, 1'b1, 8'hA0};
        exp_rx = '{8'hA0, 8'hA0, 8'hB1, 8'hD3, 8'hB1, 8'hD3, 8'hA0};

        // Reset state
        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_drop", drop, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_err", err, 0);

        // Table-driven arbitration
        out_ready = 1'b1;
        req_data = {8'hD3, 8'h00, 8'hB1, 8'hA0};
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            tick();
            check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            check($sformatf("tbl%0d_drop", i), drop, tbl[i].drop);
            check($sformatf("tbl%0d_wr_en", i), fifo_wr_en, tbl[i].wr);
            if (tbl[i].wr) check($sformatf("tbl%0d_wr_data", i), fifo_wr_data, tbl[i].wdata);
        end
        req = '0;
        repeat (24) tick();
        check("tbl_rx_size", rx_q.size(), 7);
        for (int i = 0; i < 7 && i < rx_q.size(); i++)
            check($sformatf("tbl_rx%0d", i), rx_q[i], exp_rx[i]);
        check("tbl_count_end", count, 0);

        // Round robin, all ports held
        do_reset();
        out_ready = 1'b1;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 20) begin
            tick();
            cyc++;
            if (gnt != 0) begin
                idx = 0;
                for (int p = 0; p < 4; p++) if (gnt[p]) idx = p;
                gseq[n] = idx;
                dseq[n] = fifo_wr_data;
                n++;
                if (idx != 0 || n == 5) req[idx] = 1'b0;
            end
        end
        req = '0;
        check("rr_grant_count", n, 5);
        check("rr_g0", gseq[0], 0);
        check("rr_g1", gseq[1], 1);
        check("rr_g2", gseq[2], 2);
        check("rr_g3", gseq[3], 3);
        check("rr_g4", gseq[4], 0);
        check("rr_d0", dseq[0], 8'h11);
        check("rr_d1", dseq[1], 8'h22);
        check("rr_d2", dseq[2], 8'h33);
        check("rr_d3", dseq[3], 8'h44);
        repeat (20) tick();
        check("rr_rx_size", rx_q.size(), 5);
        if (rx_q.size() >= 4) begin
            check("rr_rx0", rx_q[0], 8'h11);
            check("rr_rx1", rx_q[1], 8'h22);
            check("rr_rx2", rx_q[2], 8'h33);
            check("rr_rx3", rx_q[3], 8'h44);
        end

        // Zero word is dropped
        do_reset();
        out_ready = 1'b1;
        req_data = {8'h00, 8'h00, 8'h00, 8'h00};
        req = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            tick();
            if (gnt != 0) begin
                got = 1'b1;
                check("drop_gnt", gnt, 4'b0100);
                check("drop_drop", drop, 4'b0100);
                check("drop_wr_en", fifo_wr_en, 0);
                req = '0;
            end
        end
        check("drop_granted", got, 1);
        req = '0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid || fifo_wr_en) seen = 1'b1;
        end
        check("drop_no_valid", seen, 0);
        check("drop_count", count, 0);

        // Fill to full with consumer stalled
        do_reset();
        out_ready = 1'b0;
        d = 8'h01;
        req_data = {24'h0, d};
        req = 4'b0001;
        n = 0;
        for (int c = 0; c < 60 && n < 17; c++) begin
            tick();
            if (gnt[0]) begin
                n++;
                d = d + 8'h01;
                req_data[7:0] = d;
                if (n == 17) req[0] = 1'b0;
            end
        end
        req = '0;
        check("full_writes", n, 17);
        repeat (4) tick();
        check("full_count", count, 16);
        check("full_full", full, 1);
        check("full_count_model", count, m_cnt);
        check("full_out_valid", out_valid, 1);
        check("full_out_data", out_data, 8'h01);
        req_data = {8'h00, 8'h00, 8'h55, 8'h00};
        req = 4'b0010;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (gnt != 0) seen = 1'b1;
        end
        check("full_no_gnt", seen, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            if (gnt[1]) got = 1'b1;
            else tick();
        end
        if (gnt[1]) got = 1'b1;
        req = '0;
        check("full_port1_gnt", got, 1);
        repeat (4) tick();
        check("full_count_again", count, 16);
        check("full_full_again", full, 1);
        check("full_rx_size", rx_q.size(), 1);
        if (rx_q.size() > 0) check("full_rx0", rx_q[0], 8'h01);
        check("full_next_data", out_data, 8'h02);
        check("full_no_err", err, 0);

        // Steady streaming, one write every other cycle
        do_reset();
        out_ready = 1'b1;
        req_data = {24'h0, 8'h5A};
        req = 4'b0001;
        maxc = 0;
        nwr = 0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (int'(count) > maxc) maxc = int'(count);
            if (fifo_wr_en) nwr++;
            if (err || fifo_overflow || fifo_underflow) seen = 1'b1;
        end
        req = '0;
        repeat (10) begin
            tick();
            if (err || fifo_overflow || fifo_underflow) seen = 1'b1;
        end
        check("steady_max_count", (maxc <= 1), 1);
        check("steady_no_err", seen, 0);
        check("steady_rx_size", rx_q.size(), nwr);
        bad = 1'b0;
        foreach (rx_q[i]) if (rx_q[i] != 8'h5A) bad = 1'b1;
        check("steady_rx_data", bad, 0);
        check("steady_count_end", count, 0);

        // Reset while holding a word
        do_reset();
        req_data = {24'h0, 8'h77};
        req = 4'b0001;
        tick();
        req = '0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (out_valid) got = 1'b1;
        end
        check("hold_valid", got, 1);
        check("hold_data", out_data, 8'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("hold_rst_valid", out_valid, 0);
        check("hold_rst_count", count, 0);
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (out_valid || fifo_rd_en) seen = 1'b1;
        end
        check("hold_rst_idle", seen, 0);

        // Sticky err
        do_reset();
        force_unf = 1'b1;
        tick();
        force_unf = 1'b0;
        check("err_set", err, 1);
        repeat (5) tick();
        check("err_sticky", err, 1);
        do_reset();
        check("err_cleared", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
